mem_stage: RTL

Pipeline MEM stage: the receiving end of the EXE→MEM interface. Accepts the EXE stage's registered outputs, runs loads and stores against a request/acknowledge data-memory port, and stalls EXE until memory answers. Outputs WB-stage registers plus the WB-result forwarding pair that EXE consumes. Handles byte, halfword and word access with lane alignment, sign/zero extension and misalignment detection.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_stage_if.sv | 33 +++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Opcodes, FSM states, access sizes and a byte-enable helper.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    function automatic logic [3:0] be_of(size_t sz, logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data-memory port between MEM stage and memory.
// master = MEM stage, slave = memory.
interface mem_stage_if;

    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [3:0]  DMEM_BE;
    logic [31:0] DMEM_WDATA;
    logic [31:0] DMEM_RDATA;
    logic        DMEM_ACK;

    modport master (
        output DMEM_REQ,
        output DMEM_WE,
        output DMEM_ADDR,
        output DMEM_BE,
        output DMEM_WDATA,
        input  DMEM_RDATA,
        input  DMEM_ACK
    );

    modport slave (
        input  DMEM_REQ,
        input  DMEM_WE,
        input  DMEM_ADDR,
        input  DMEM_BE,
        input  DMEM_WDATA,
        output DMEM_RDATA,
        output DMEM_ACK
    );

endinterface

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed lane(s) out of the read word
// and sign- or zero-extends to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  size_t       size,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    data = {{24{sgn & b[7]}}, b};
            SZ_H:    data = {{16{sgn & h[15]}}, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the DMEM port, stalls EXE
// until ACK, and registers results into the WB stage.
module mem_stage
    import mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    output logic        Stall_OUT,
    mem_stage_if.master dmem,
    output logic        Addr_Error_OUT,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] WriteData1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic        RegWrite1_OUT,
    output logic [4:0]  WBWriteReg_OUT,
    output logic [31:0] WB_result_OUT
);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] p_instr_q, p_instr_d;
    logic [31:0] p_pc_q, p_pc_d;
    logic [4:0]  p_wreg_q, p_wreg_d;
    logic        p_rw_q, p_rw_d;
    logic        p_ld_q, p_ld_d;
    size_t       p_size_q, p_size_d;
    logic        p_sgn_q, p_sgn_d;
    logic [1:0]  p_lane_q, p_lane_d;

    logic [31:0] wb_instr_q, wb_instr_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_wreg_q, wb_wreg_d;
    logic        wb_rw_q, wb_rw_d;
    logic        aerr_q, aerr_d;

    size_t       size;
    logic        sgn;
    logic        legal;
    logic        mis;
    logic        is_mem;
    logic        err;
    logic [1:0]  lane;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    assign lane   = ALU_result1_IN[1:0];
    assign is_mem = MemRead1_IN | MemWrite1_IN;

    always_comb begin
        size  = SZ_W;
        sgn   = 1'b0;
        legal = 1'b1;
        case (ALU_Control1_IN)
            OP_LB:   begin size = SZ_B; sgn = 1'b1; end
            OP_LH:   begin size = SZ_H; sgn = 1'b1; end
            OP_LW:   size = SZ_W;
            OP_LBU:  size = SZ_B;
            OP_LHU:  size = SZ_H;
            OP_SB:   size = SZ_B;
            OP_SH:   size = SZ_H;
            OP_SW:   size = SZ_W;
            default: legal = 1'b0;
        endcase
        mis = ((size == SZ_H) && lane[0]) ||
              ((size == SZ_W) && (lane != 2'b00));
        err = is_mem &&
              (!legal || (MemRead1_IN && MemWrite1_IN) || mis);
        case (size)
            SZ_B:    st_data = {4{MemWriteData1_IN[7:0]}};
            SZ_H:    st_data = {2{MemWriteData1_IN[15:0]}};
            default: st_data = MemWriteData1_IN;
        endcase
    end

    mem_load_align u_align (
        .rdata (dmem.DMEM_RDATA),
        .lane  (p_lane_q),
        .size  (p_size_q),
        .sgn   (p_sgn_q),
        .data  (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        p_instr_d  = p_instr_q;
        p_pc_d     = p_pc_q;
        p_wreg_d   = p_wreg_q;
        p_rw_d     = p_rw_q;
        p_ld_d     = p_ld_q;
        p_size_d   = p_size_q;
        p_sgn_d    = p_sgn_q;
        p_lane_d   = p_lane_q;
        // WB registers hold a bubble unless something retires
        wb_instr_d = '0;
        wb_pc_d    = '0;
        wb_data_d  = '0;
        wb_wreg_d  = '0;
        wb_rw_d    = 1'b0;
        aerr_d     = 1'b0;
        Stall_OUT  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!is_mem) begin
                    wb_instr_d = Instr1_IN;
                    wb_pc_d    = Instr1_PC_IN;
                    wb_data_d  = ALU_result1_IN;
                    wb_wreg_d  = WriteRegister1_IN;
                    wb_rw_d    = RegWrite1_IN;
                end else if (err) begin
                    aerr_d = 1'b1;
                end else begin
                    Stall_OUT = 1'b1;
                    state_d   = S_WAIT;
                    req_d     = 1'b1;
                    we_d      = MemWrite1_IN;
                    addr_d    = {ALU_result1_IN[31:2], 2'b00};
                    be_d      = be_of(size, lane);
                    wdata_d   = st_data;
                    p_instr_d = Instr1_IN;
                    p_pc_d    = Instr1_PC_IN;
                    p_wreg_d  = WriteRegister1_IN;
                    p_rw_d    = RegWrite1_IN & MemRead1_IN;
                    p_ld_d    = MemRead1_IN;
                    p_size_d  = size;
                    p_sgn_d   = sgn;
                    p_lane_d  = lane;
                end
            end
            default: begin
                if (!dmem.DMEM_ACK) begin
                    Stall_OUT = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = '0;
                    be_d       = '0;
                    wdata_d    = '0;
                    wb_instr_d = p_instr_q;
                    wb_pc_d    = p_pc_q;
                    wb_data_d  = p_ld_q ? ld_data : '0;
                    wb_wreg_d  = p_wreg_q;
                    wb_rw_d    = p_rw_q;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            p_instr_q  <= '0;
            p_pc_q     <= '0;
            p_wreg_q   <= '0;
            p_rw_q     <= 1'b0;
            p_ld_q     <= 1'b0;
            p_size_q   <= SZ_B;
            p_sgn_q    <= 1'b0;
            p_lane_q   <= '0;
            wb_instr_q <= '0;
            wb_pc_q    <= '0;
            wb_data_q  <= '0;
            wb_wreg_q  <= '0;
            wb_rw_q    <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            p_instr_q  <= p_instr_d;
            p_pc_q     <= p_pc_d;
            p_wreg_q   <= p_wreg_d;
            p_rw_q     <= p_rw_d;
            p_ld_q     <= p_ld_d;
            p_size_q   <= p_size_d;
            p_sgn_q    <= p_sgn_d;
            p_lane_q   <= p_lane_d;
            wb_instr_q <= wb_instr_d;
            wb_pc_q    <= wb_pc_d;
            wb_data_q  <= wb_data_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_rw_q    <= wb_rw_d;
            aerr_q     <= aerr_d;
        end
    end

    assign dmem.DMEM_REQ   = req_q;
    assign dmem.DMEM_WE    = we_q;
    assign dmem.DMEM_ADDR  = addr_q;
    assign dmem.DMEM_BE    = be_q;
    assign dmem.DMEM_WDATA = wdata_q;

    assign Addr_Error_OUT     = aerr_q;
    assign Instr1_OUT         = wb_instr_q;
    assign Instr1_PC_OUT      = wb_pc_q;
    assign WriteData1_OUT     = wb_data_q;
    assign WriteRegister1_OUT = wb_wreg_q;
    assign RegWrite1_OUT      = wb_rw_q;
    assign WBWriteReg_OUT     = wb_rw_q ? wb_wreg_q : 5'd0;
    assign WB_result_OUT      = wb_data_q;

endmodule
